// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder
//   Multi-cycle two's-complement adder/subtractor. Operands are summed CHUNK
//   bits per clock, least-significant chunk first, with the carry held in a
//   register between chunks. Supports A+B+cin, A-B, signed overflow detection
//   and optional saturation, with valid/ready handshakes on both sides.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_valid     operands/mode valid (sampled only while idle)
//   o_ready     idle and able to accept an operation
//   i_add1      operand A (signed)
//   i_add2      operand B (signed)
//   i_sub       1: A-B, 0: A+B+i_cin
//   i_cin       carry-in for add mode, ignored when subtracting
//   o_valid     result valid, held until i_ready
//   i_ready     consumer accepts the result
//   o_result    sum/difference, clamped on overflow when SATURATE=1
//   o_carry     raw carry out of the MSB (subtract: 1 = no borrow)
//   o_overflow  signed overflow flag, independent of SATURATE
module chunked_serial_adder #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHUNK    = 2,
    parameter int unsigned SATURATE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    input  logic             i_sub,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]    LAST = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a, b_eff, raw, raw_next, sat_val;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [CHUNK:0]   csum;
    int unsigned      base;
    logic             last, ovf;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_next = RUN;
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Chunk adder. Shifts select the current chunk and merge it back into the
    // raw result, so the chunk position never needs a variable part-select.
    always_comb begin
        base     = int'(cnt) * CHUNK;
        csum     = {1'b0, CHUNK'(a >> base)} + {1'b0, CHUNK'(b_eff >> base)}
                   + (CHUNK + 1)'(carry);
        raw_next = (raw & ~(MASK << base)) | (WIDTH'(csum[CHUNK-1:0]) << base);
        last     = (cnt == LAST);
        ovf      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (raw_next[WIDTH-1] != a[WIDTH-1]);
        sat_val  = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    // Datapath
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a          <= '0;
            b_eff      <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            raw        <= '0;
            o_result   <= '0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a     <= i_add1;
                        b_eff <= i_sub ? ~i_add2 : i_add2;
                        carry <= i_sub | i_cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    raw   <= raw_next;
                    carry <= csum[CHUNK];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        o_carry    <= csum[CHUNK];
                        o_overflow <= ovf;
                        o_result   <= (SATURATE != 0 && ovf) ? sat_val : raw_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Testbench for chunked_serial_adder. Three instances at WIDTH=8:
//   dut0: CHUNK=2 SATURATE=1, dut1: CHUNK=2 SATURATE=0, dut2: CHUNK=8 SATURATE=1.
// Stimulus pushes hand-computed expectations into per-instance queues; a
// monitor pops and compares whenever an instance presents o_valid.
module tb_chunked_serial_adder;

    typedef struct {
        logic [7:0]  res;
        logic        c;
        logic        v;
        int unsigned cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] vin = '0;
    logic [7:0] add1 = '0, add2 = '0;
    logic       sub = 1'b0, cin = 1'b0, iready = 1'b1;
    logic [2:0] ordy, ovalid, ocarry, oovf;
    logic [7:0] res [3];

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    exp_t sbq [3][$];
    exp_t cur [3];
    logic [2:0] have = '0;
    logic [2:0] rdy_pend = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        chunked_serial_adder #(
            .WIDTH(8),
            .CHUNK((g == 2) ? 8 : 2),
            .SATURATE((g == 1) ? 0 : 1)
        ) u_dut (
            .i_clk(clk),
            .i_rst(rst),
            .i_valid(vin[g]),
            .o_ready(ordy[g]),
            .i_add1(add1),
            .i_add2(add2),
            .i_sub(sub),
            .i_cin(cin),
            .o_valid(ovalid[g]),
            .i_ready(iready),
            .o_result(res[g]),
            .o_carry(ocarry[g]),
            .o_overflow(oovf[g])
        );
    end

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at cycle %0d", name, d, act, exp, cyc);
    endtask

    // Monitor: compares outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rdy_pend[d]) begin
                chk("ready_after_consume", d, 32'(ordy[d]), 32'd1);
                rdy_pend[d] = 1'b0;
            end
            if (ovalid[d] === 1'b1) begin
                chk("ready_low_in_done", d, 32'(ordy[d]), 32'd0);
                if (!have[d]) begin
                    if (sbq[d].size() == 0) begin
                        chk("unexpected_valid", d, 32'd1, 32'd0);
                    end else begin
                        cur[d]  = sbq[d].pop_front();
                        have[d] = 1'b1;
                        chk("latency", d, cyc, cur[d].cyc);
                    end
                end
                if (have[d]) begin
                    chk("result", d, 32'(res[d]), 32'(cur[d].res));
                    chk("carry", d, 32'(ocarry[d]), 32'(cur[d].c));
                    chk("overflow", d, 32'(oovf[d]), 32'(cur[d].v));
                end
                if (iready) begin
                    have[d]     = 1'b0;
                    rdy_pend[d] = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input logic [2:0] mask);
        for (int i = 0; i < 60; i++) begin
            if ((ordy & mask) == mask) return;
            step();
        end
        chk("wait_ready_timeout", 0, 32'(ordy & mask), 32'(mask));
    endtask

    task automatic drain();
        for (int i = 0; i < 80; i++) begin
            if (sbq[0].size() == 0 && sbq[1].size() == 0 && sbq[2].size() == 0 &&
                have == 3'b000 && ordy == 3'b111) return;
            step();
        end
        chk("drain_timeout", 0, 32'(ordy), 32'h7);
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s, input logic ci,
                         input logic [2:0] mask, input logic [7:0] e_sat, input logic [7:0] e_wrap,
                         input logic ec, input logic ev);
        exp_t e;
        wait_ready(mask);
        add1 = a; add2 = b; sub = s; cin = ci; vin = mask;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (mask[d]) begin
                e.res = (d == 1) ? e_wrap : e_sat;
                e.c   = ec;
                e.v   = ev;
                e.cyc = cyc + ((d == 2) ? 1 : 4);
                sbq[d].push_back(e);
            end
        end
        #1;
        vin = '0;
    endtask

    task automatic check_reset_outputs();
        for (int d = 0; d < 3; d++) begin
            chk("rst_valid", d, 32'(ovalid[d]), 32'd0);
            chk("rst_ready", d, 32'(ordy[d]), 32'd1);
            chk("rst_result", d, 32'(res[d]), 32'd0);
            chk("rst_carry", d, 32'(ocarry[d]), 32'd0);
            chk("rst_overflow", d, 32'(oovf[d]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_reset_outputs();

        // Basic add, overflows, subtracts (i_cin=1 must be ignored when subtracting)
        issue(8'h35, 8'h4A, 1'b0, 1'b0, 3'b111, 8'h7F, 8'h7F, 1'b0, 1'b0);
        issue(8'h70, 8'h20, 1'b0, 1'b0, 3'b111, 8'h7F, 8'h90, 1'b0, 1'b1);
        issue(8'h10, 8'h20, 1'b1, 1'b1, 3'b111, 8'hF0, 8'hF0, 1'b0, 1'b0);
        issue(8'h80, 8'h01, 1'b1, 1'b1, 3'b111, 8'h80, 8'h7F, 1'b1, 1'b1);
        issue(8'h0F, 8'h01, 1'b0, 1'b1, 3'b111, 8'h11, 8'h11, 1'b0, 1'b0);
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 3'b111, 8'h00, 8'h00, 1'b1, 1'b0);
        issue(8'h80, 8'h80, 1'b0, 1'b0, 3'b111, 8'h80, 8'h00, 1'b1, 1'b1);
        issue(8'h7F, 8'hFF, 1'b1, 1'b0, 3'b111, 8'h7F, 8'h80, 1'b0, 1'b1);
        drain();

        // Backpressure: hold results, ignore a request made during the stall
        iready = 1'b0;
        issue(8'h12, 8'h34, 1'b0, 1'b0, 3'b111, 8'h46, 8'h46, 1'b0, 1'b0);
        for (int i = 0; i < 40 && ovalid != 3'b111; i++) step();
        chk("stall_all_valid", 0, 32'(ovalid), 32'h7);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_ready_low", 0, 32'(ordy), 32'h0);
            if (i == 1) begin
                add1 = 8'h55; add2 = 8'h55; sub = 1'b0; cin = 1'b0; vin = 3'b111;
            end else begin
                vin = '0;
            end
        end
        iready = 1'b1;
        drain();
        issue(8'h21, 8'h12, 1'b0, 1'b0, 3'b111, 8'h33, 8'h33, 1'b0, 1'b0);
        drain();

        // Reset on the second RUN edge: no result may appear
        add1 = 8'h33; add2 = 8'h11; sub = 1'b0; cin = 1'b0; vin = 3'b011;
        step();
        vin = '0;
        chk("abort_accepted", 0, 32'(ordy[1:0]), 32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs();
        issue(8'h01, 8'h01, 1'b0, 1'b0, 3'b111, 8'h02, 8'h02, 1'b0, 1'b0);
        drain();
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
